dmem_master: RTL and testbench

- Load/store initiator sitting between the pipeline memory stage and the word-addressed data memory (combinational read, byte-strobed synchronous write).
- Accepts one load/store request per transaction and drives word address, write data, CE and byte strobes.
- Extracts and sign/zero-extends load data; detects misaligned, out-of-range and illegal accesses.
- Returns a result over a valid/ready response channel.

---
 rtl/dmem_master.sv | 138 +++++++++++++
 tb/tb_dmem_master.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_master.sv
// Load/store initiator for a word-addressed data memory: OK requests take IDLE->ACCESS->RESP, faulting requests go straight to RESP.
// A response is held with RSP_VALID until RSP_READY, and no new request is taken until the block is back in IDLE.
module dmem_master #(
   parameter logic [31:0] DMEM_BASE  = 32'h0000_0000,
   parameter int unsigned DMEM_WORDS = 32768
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic        REQ_WE,
   input  logic [2:0]  REQ_FUNCT3,
   input  logic [31:0] REQ_ADDR,
   input  logic [31:0] REQ_WDATA,
   output logic        RSP_VALID,
   input  logic        RSP_READY,
   output logic [31:0] RSP_RDATA,
   output logic [1:0]  RSP_ERR,
   output logic [29:0] MEM_ADDR,
   output logic [31:0] MEM_DATAO,
   input  logic [31:0] MEM_DATAI,
   output logic        MEM_CE,
   output logic [3:0]  MEM_WSTB
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [32:0] DMEM_BYTES = 33'(DMEM_WORDS) << 2;
   localparam logic [1:0]  ERR_OK     = 2'b00;
   localparam logic [1:0]  ERR_MISAL  = 2'b01;
   localparam logic [1:0]  ERR_FAULT  = 2'b10;
   localparam logic [1:0]  ERR_ILL    = 2'b11;

   state_t      state, state_nxt;
   logic        accept;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [1:0]  off_q;
   logic [1:0]  chk_err;
   logic [32:0] offset;
   logic [31:0] wdata_lanes;
   logic [31:0] shifted;
   logic [31:0] load_data;
   logic [3:0]  wstb;

   assign accept = REQ_VALID && REQ_READY;

   // Checks are evaluated on the values being latched so the error path can skip ACCESS.
   always_comb begin
      offset  = {1'b0, REQ_ADDR} - {1'b0, DMEM_BASE};
      chk_err = ERR_OK;
      if (REQ_WE ? (REQ_FUNCT3 >= 3'b011)
                 : (REQ_FUNCT3 == 3'b011 || REQ_FUNCT3[2:1] == 2'b11))
         chk_err = ERR_ILL;
      else if ((REQ_FUNCT3[1:0] == 2'b01 && REQ_ADDR[0]) ||
               (REQ_FUNCT3[1:0] == 2'b10 && REQ_ADDR[1:0] != 2'b00))
         chk_err = ERR_MISAL;
      else if (offset[32] || offset >= DMEM_BYTES)
         chk_err = ERR_FAULT;
   end

   always_comb begin
      case (REQ_FUNCT3[1:0])
         2'b00:   wdata_lanes = {4{REQ_WDATA[7:0]}};
         2'b01:   wdata_lanes = {2{REQ_WDATA[15:0]}};
         default: wdata_lanes = REQ_WDATA;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = (chk_err == ERR_OK) ? ACCESS : RESP;
         ACCESS:  state_nxt = RESP;
         RESP:    if (RSP_READY) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      REQ_READY = (state == IDLE) && !RST;
      RSP_VALID = (state == RESP);
      MEM_CE    = (state == ACCESS) && !RST;
      MEM_WSTB  = (MEM_CE && we_q) ? wstb : 4'b0000;
   end

   always_comb begin
      case (funct3_q[1:0])
         2'b00:   wstb = 4'b0001 << off_q;
         2'b01:   wstb = 4'b0011 << {off_q[1], 1'b0};
         default: wstb = 4'b1111;
      endcase
   end

   always_comb begin
      shifted = MEM_DATAI >> {off_q, 3'b000};
      case (funct3_q)
         3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_data = {24'd0, shifted[7:0]};
         3'b101:  load_data = {16'd0, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

   // MEM_ADDR/MEM_DATAO double as the latched address and write data; they only move on an OK accept.
   always_ff @(posedge CLK) begin
      if (RST) begin
         we_q      <= 1'b0;
         funct3_q  <= 3'b000;
         off_q     <= 2'b00;
         RSP_ERR   <= ERR_OK;
         RSP_RDATA <= 32'd0;
         MEM_ADDR  <= 30'd0;
         MEM_DATAO <= 32'd0;
      end else if (accept) begin
         we_q      <= REQ_WE;
         funct3_q  <= REQ_FUNCT3;
         off_q     <= REQ_ADDR[1:0];
         RSP_ERR   <= chk_err;
         RSP_RDATA <= 32'd0;
         if (chk_err == ERR_OK) begin
            MEM_ADDR  <= REQ_ADDR[31:2];
            MEM_DATAO <= wdata_lanes;
         end
      end else if (state == ACCESS && !we_q) begin
         RSP_RDATA <= load_data;
      end
   end

endmodule

// File: tb/tb_dmem_master.sv
// Bench for dmem_master: byte-level reference memory and transaction model, per-cycle compare, directed and random traffic.
module tb_dmem_master;

   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int unsigned WORDS = 32768;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        REQ_VALID = 1'b0;
   logic        REQ_READY;
   logic        REQ_WE = 1'b0;
   logic [2:0]  REQ_FUNCT3 = 3'd0;
   logic [31:0] REQ_ADDR = 32'd0;
   logic [31:0] REQ_WDATA = 32'd0;
   logic        RSP_VALID;
   logic        RSP_READY = 1'b0;
   logic [31:0] RSP_RDATA;
   logic [1:0]  RSP_ERR;
   logic [29:0] MEM_ADDR;
   logic [31:0] MEM_DATAO;
   logic [31:0] MEM_DATAI;
   logic        MEM_CE;
   logic [3:0]  MEM_WSTB;

   dmem_master #(.DMEM_BASE(BASE), .DMEM_WORDS(WORDS)) dut (
      .CLK(CLK), .RST(RST),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
      .REQ_FUNCT3(REQ_FUNCT3), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
      .MEM_ADDR(MEM_ADDR), .MEM_DATAO(MEM_DATAO), .MEM_DATAI(MEM_DATAI),
      .MEM_CE(MEM_CE), .MEM_WSTB(MEM_WSTB)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [31:0] init_word(input int i);
      return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
   endfunction

   // Memory seen by the DUT: 256 words, aliased on address bits [9:2].
   logic [31:0] dmem [0:255];
   logic        mem_init = 1'b1;
   assign MEM_DATAI = dmem[MEM_ADDR[7:0]];

   always @(posedge CLK) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) dmem[i] <= init_word(i);
      end else if (MEM_CE) begin
         for (int b = 0; b < 4; b++)
            if (MEM_WSTB[b]) dmem[MEM_ADDR[7:0]][8*b +: 8] <= MEM_DATAO[8*b +: 8];
      end
   end

   // ---------------- reference model (byte-oriented) ----------------
   function automatic int nbytes(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [1:0] model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
      bit     legal;
      longint off;
      if (we) legal = (f3 <= 3'd2);
      else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      if (!legal) return 2'b11;
      if ((addr % 32'(nbytes(f3))) != 32'd0) return 2'b01;
      off = longint'(addr) - longint'(BASE);
      if (off < 0 || off >= longint'(WORDS) * 4) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] word);
      logic [31:0] v;
      int n;
      v = 32'd0;
      n = nbytes(f3);
      for (int k = 0; k < n; k++) v[8*k +: 8] = word[8*(int'(off) + k) +: 8];
      if (!f3[2] && n < 4 && v[8*n-1])
         for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
      return v;
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] old, input logic [2:0] f3,
                                               input logic [1:0] off, input logic [31:0] wdata);
      logic [31:0] v;
      v = old;
      for (int k = 0; k < nbytes(f3); k++) v[8*(int'(off) + k) +: 8] = wdata[8*k +: 8];
      return v;
   endfunction

   function automatic logic [3:0] model_wstb(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] s;
      s = 4'b0000;
      for (int k = 0; k < nbytes(f3); k++)
         if (int'(off) + k < 4) s[int'(off) + k] = 1'b1;
      return s;
   endfunction

   function automatic logic [31:0] model_datao(input logic [2:0] f3, input logic [31:0] wdata);
      logic [31:0] d;
      for (int i = 0; i < 4; i++) d[8*i +: 8] = wdata[8*(i % nbytes(f3)) +: 8];
      return d;
   endfunction

   logic [31:0] ref_mem [0:255];
   bit          pend = 1'b0;
   int          age = 0;
   logic        e_we;
   logic [2:0]  e_f3;
   logic [31:0] e_addr, e_wdata, e_rdata, e_datao;
   logic [1:0]  e_err = 2'b00;
   logic [3:0]  e_wstb;
   logic        m_vld, m_acc;

   // Transaction timeline relative to the accept edge: memory cycle right after it, response after that;
   // a faulting request responds right after the accept edge.
   assign m_vld = pend && (e_err != 2'b00 || age >= 1);
   assign m_acc = pend && e_err == 2'b00 && age == 0;

   always @(posedge CLK) begin
      if (mem_init)
         for (int i = 0; i < 256; i++) ref_mem[i] <= init_word(i);
      if (RST) begin
         pend <= 1'b0;
      end else if (pend) begin
         if (m_vld && RSP_READY) begin
            pend <= 1'b0;
         end else begin
            if (m_acc && e_we)
               ref_mem[e_addr[9:2]] <= model_store(ref_mem[e_addr[9:2]], e_f3, e_addr[1:0], e_wdata);
            age <= age + 1;
         end
      end else if (REQ_VALID) begin
         pend    <= 1'b1;
         age     <= 0;
         e_we    <= REQ_WE;
         e_f3    <= REQ_FUNCT3;
         e_addr  <= REQ_ADDR;
         e_wdata <= REQ_WDATA;
         e_err   <= model_err(REQ_WE, REQ_FUNCT3, REQ_ADDR);
         e_rdata <= (REQ_WE || model_err(REQ_WE, REQ_FUNCT3, REQ_ADDR) != 2'b00) ? 32'd0
                    : model_load(REQ_FUNCT3, REQ_ADDR[1:0], ref_mem[REQ_ADDR[9:2]]);
         e_wstb  <= REQ_WE ? model_wstb(REQ_FUNCT3, REQ_ADDR[1:0]) : 4'b0000;
         e_datao <= model_datao(REQ_FUNCT3, REQ_WDATA);
      end
   end

   // ---------------- per-cycle compare ----------------
   int          ce_cnt = 0;
   logic [3:0]  last_wstb = 4'd0;
   logic [31:0] last_datao = 32'd0;
   logic [29:0] last_addr = 30'd0;

   initial begin
      logic exp_acc;
      forever begin
         @(negedge CLK);
         exp_acc = m_acc && !RST;
         check("req_ready", 32'(REQ_READY), 32'(!pend && !RST));
         check("mem_ce", 32'(MEM_CE), 32'(exp_acc));
         check("mem_wstb", 32'(MEM_WSTB), exp_acc ? 32'(e_wstb) : 32'd0);
         if (exp_acc) begin
            check("mem_addr", 32'(MEM_ADDR), 32'(e_addr[31:2]));
            if (e_we) check("mem_datao", MEM_DATAO, e_datao);
         end
         if (MEM_CE) begin
            ce_cnt++;
            last_wstb  = MEM_WSTB;
            last_datao = MEM_DATAO;
            last_addr  = MEM_ADDR;
         end
         check("rsp_valid", 32'(RSP_VALID), 32'(m_vld));
         if (m_vld) begin
            check("rsp_rdata", RSP_RDATA, e_rdata);
            check("rsp_err", 32'(RSP_ERR), 32'(e_err));
         end
      end
   end

   // ---------------- driver ----------------
   logic [31:0] t_rd;
   logic [1:0]  t_er;
   int          t_lat, t_ces;

   task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                      input int hold, input bit early,
                      output logic [31:0] rd, output logic [1:0] er, output int lat, output int ces);
      int n, ce0;
      n = 0;
      @(negedge CLK);
      while (!REQ_READY && n < 50) begin @(negedge CLK); n++; end
      if (!REQ_READY) check("req_ready_timeout", 32'(REQ_READY), 32'd1);
      REQ_VALID = 1'b1; REQ_WE = we; REQ_FUNCT3 = f3; REQ_ADDR = addr; REQ_WDATA = wdata;
      ce0 = ce_cnt;
      @(posedge CLK); #1;
      REQ_VALID = 1'b0; REQ_WE = 1'($urandom); REQ_FUNCT3 = 3'($urandom);
      REQ_ADDR = $urandom; REQ_WDATA = $urandom;
      if (early && hold == 0) RSP_READY = 1'b1;
      lat = 0;
      do begin @(negedge CLK); lat++; end while (!RSP_VALID && lat < 20);
      if (!RSP_VALID) check("rsp_timeout", 32'(RSP_VALID), 32'd1);
      rd = RSP_RDATA;
      er = RSP_ERR;
      for (int h = 0; h < hold; h++) begin
         check("hold_req_ready", 32'(REQ_READY), 32'd0);
         @(negedge CLK);
         check("hold_valid", 32'(RSP_VALID), 32'd1);
         check("hold_rdata", RSP_RDATA, rd);
      end
      RSP_READY = 1'b1;
      @(posedge CLK); #1;
      RSP_READY = 1'b0;
      ces = ce_cnt - ce0;
   endtask

   logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete (%0d/%0d so far)", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          r, hold;

      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_req_ready", 32'(REQ_READY), 32'd0);
      check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
      check("rst_rsp_err", 32'(RSP_ERR), 32'd0);
      check("rst_rsp_rdata", RSP_RDATA, 32'd0);
      check("rst_mem_addr", 32'(MEM_ADDR), 32'd0);
      @(posedge CLK); #1;
      RST = 1'b0; mem_init = 1'b0;
      @(negedge CLK);
      check("idle_req_ready", 32'(REQ_READY), 32'd1);

      txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 1'b0, t_rd, t_er, t_lat, t_ces);
      check("sw_err", 32'(t_er), 32'd0);
      check("sw_lat", 32'(t_lat), 32'd2);
      check("sw_ces", 32'(t_ces), 32'd1);
      check("sw_wstb", 32'(last_wstb), 32'hF);
      check("sw_addr", 32'(last_addr), 32'd4);
      txn(1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0, t_rd, t_er, t_lat, t_ces);
      check("lw_rdata", t_rd, 32'hDEADBEEF);
      check("lw_err", 32'(t_er), 32'd0);
      check("lw_lat", 32'(t_lat), 32'd2);
      check("lw_ces", 32'(t_ces), 32'd1);

      txn(1'b1, 3'd0, 32'h22, 32'h000000F0, 0, 1'b0, t_rd, t_er, t_lat, t_ces);
      check("sb_wstb", 32'(last_wstb), 32'h4);
      check("sb_datao", last_datao, 32'hF0F0F0F0);
      txn(1'b0, 3'd0, 32'h22, 32'h0, 0, 1'b0, t_rd, t_er, t_lat, t_ces);
      check("lb_rdata", t_rd, 32'hFFFFFFF0);
      txn(1'b0, 3'd4, 32'h22, 32'h0, 0, 1'b0, t_rd, t_er, t_lat, t_ces);
      check("lbu_rdata", t_rd, 32'h000000F0);

      txn(1'b1, 3'd2, 32'h30, 32'h80017FFF, 0, 1'b0, t_rd, t_er, t_lat, t_ces);
      txn(1'b0, 3'd1, 32'h32, 32'h0, 0, 1'b0, t_rd, t_er, t_lat, t_ces);
      check("lh_rdata", t_rd, 32'hFFFF8001);
      txn(1'b0, 3'd5, 32'h30, 32'h0, 0, 1'b0, t_rd, t_er, t_lat, t_ces);
      check("lhu_rdata", t_rd, 32'h00007FFF);

      txn(1'b0, 3'd2, 32'h13, 32'h0, 0, 1'b0, t_rd, t_er, t_lat, t_ces);
      check("misal_err", 32'(t_er), 32'd1);
      check("misal_ces", 32'(t_ces), 32'd0);
      check("misal_lat", 32'(t_lat), 32'd1);
      check("misal_rdata", t_rd, 32'd0);
      txn(1'b0, 3'd3, 32'h20, 32'h0, 0, 1'b0, t_rd, t_er, t_lat, t_ces);
      check("illegal_err", 32'(t_er), 32'd3);
      txn(1'b1, 3'd2, BASE + 32'h20000, 32'h12345678, 0, 1'b0, t_rd, t_er, t_lat, t_ces);
      check("fault_err", 32'(t_er), 32'd2);
      check("fault_ces", 32'(t_ces), 32'd0);
      txn(1'b1, 3'd2, BASE + 32'h1FFFC, 32'h0BADF00D, 0, 1'b0, t_rd, t_er, t_lat, t_ces);
      check("top_word_err", 32'(t_er), 32'd0);

      txn(1'b0, 3'd2, 32'h30, 32'h0, 3, 1'b0, t_rd, t_er, t_lat, t_ces);
      check("bp_rdata", t_rd, 32'h80017FFF);
      @(negedge CLK);
      check("bp_idle_after", 32'(REQ_READY), 32'd1);

      // Reset in the middle of a store's memory cycle.
      txn(1'b1, 3'd2, 32'h40, 32'h11111111, 0, 1'b0, t_rd, t_er, t_lat, t_ces);
      @(negedge CLK);
      REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_FUNCT3 = 3'd2; REQ_ADDR = 32'h40; REQ_WDATA = 32'hCAFEF00D;
      @(posedge CLK); #1;
      REQ_VALID = 1'b0;
      RST = 1'b1;
      @(negedge CLK);
      check("rst_acc_wstb", 32'(MEM_WSTB), 32'd0);
      check("rst_acc_ce", 32'(MEM_CE), 32'd0);
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      check("post_rst_valid", 32'(RSP_VALID), 32'd0);
      check("post_rst_ready", 32'(REQ_READY), 32'd1);
      check("post_rst_mem_addr", 32'(MEM_ADDR), 32'd0);
      txn(1'b0, 3'd2, 32'h40, 32'h0, 0, 1'b0, t_rd, t_er, t_lat, t_ces);
      check("rst_old_data", t_rd, 32'h11111111);

      for (int t = 0; t < 400; t++) begin
         we = 1'($urandom);
         if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
         else if (we) f3 = 3'($urandom_range(0, 2));
         else f3 = ld_f3[$urandom_range(0, 4)];
         r = int'($urandom_range(0, 19));
         if (r < 16) begin
            addr = 32'($urandom_range(0, 32'h3FF));
            if (r < 14) addr = addr & ~(32'(nbytes(f3)) - 32'd1);
         end else if (r == 16) addr = BASE + 32'h1FFFC + 32'($urandom_range(0, 3));
         else if (r == 17) addr = BASE + 32'h20000 + 32'($urandom_range(0, 3));
         else addr = $urandom;
         hold = int'($urandom_range(0, 3));
         txn(we, f3, addr, $urandom, hold, 1'($urandom), t_rd, t_er, t_lat, t_ces);
      end

      repeat (2) @(posedge CLK);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
